// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per channel a synchroniser, counter
// debouncer and a press/long-press/auto-repeat FSM, all outputs registered.
module button_channel #(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic x_i,
    input  logic rpt_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic rpt_o
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          deb_q;
    logic [HW-1:0]          hold_q;
    logic [RW-1:0]          rep_q;
    logic                   level_q, press_q, release_q, long_q, rpt_q;

    logic s, differ, toggle;
    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = (s != level_q);
    assign toggle = differ && (deb_q == DEB_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], x_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;

            if (!differ) begin
                deb_q <= '0;
            end else if (toggle) begin
                deb_q     <= '0;
                level_q   <= s;
                press_q   <= s;
                release_q <= !s;
            end else begin
                deb_q <= deb_q + DW'(1);
            end

            // An accepted release wins over any hold/repeat event on the same edge.
            if (toggle && !s) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (toggle && s) begin
                        state_q <= HELD;
                        hold_q  <= '0;
                    end
                    HELD: if (hold_q == HOLD_LAST) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        rep_q   <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                    LONG: if (!rpt_en_i) begin
                        rep_q <= '0;
                    end else if (rep_q == REP_LAST) begin
                        rpt_q <= 1'b1;
                        rep_q <= '0;
                    end else begin
                        rep_q <= rep_q + RW'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign rpt_o        = rpt_q;
endmodule

module button_conditioner #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] rpt_en_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_press_o,
    output logic [N-1:0] rpt_o
);
    for (genvar ch = 0; ch < N; ch++) begin : g_ch
        button_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .x_i         (x_i[ch]),
            .rpt_en_i    (rpt_en_i[ch]),
            .level_o     (level_o[ch]),
            .press_o     (press_o[ch]),
            .release_o   (release_o[ch]),
            .long_press_o(long_press_o[ch]),
            .rpt_o       (rpt_o[ch])
        );
    end
endmodule
